// File: rtl/lsu_if.sv
// Bundles the core-side request/response signals and the word-only data memory
// port of the load/store controller.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, done, err, rdata, MemRead, MemWrite, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, done, err, rdata, MemRead, MemWrite, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: byte/half/word loads with extension, word stores, and
// sub-word stores as a read-modify-write against a word-only data memory.
module lsu_ctrl #(
  parameter int MEM_WORDS = 256
) (
  input logic clk,
  input logic rst,
  lsu_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STORE  = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [2:0]  state;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] merge_buf;
  logic        done_r;
  logic        err_r;
  logic [31:0] rdata_r;

  logic        req_bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Errors are judged on the incoming request so the error pulse lands one cycle after acceptance.
  always_comb begin
    req_bad = 1'b0;
    case (bus.req_size)
      2'b00: req_bad = 1'b0;
      2'b01: req_bad = bus.req_addr[0];
      2'b10: req_bad = (bus.req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
    if ({1'b0, bus.req_addr} >= ADDR_LIMIT) req_bad = 1'b1;
  end

  always_comb begin
    lane_b = bus.mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
    lane_h = lat_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (lat_size)
      2'b00:   load_val = {{24{~lat_unsigned & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{~lat_unsigned & lane_h[15]}}, lane_h};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merge_val = merge_buf;
    if (lat_size == 2'b00)
      merge_val[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    else
      merge_val[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.MemRead   = (state == LOAD) || (state == RMW_RD);
  assign bus.MemWrite  = (state == STORE) || (state == RMW_WR);
  assign bus.mem_addr  = (state == IDLE) ? 32'd0 : {lat_addr[31:2], 2'b00};
  assign bus.mem_wdata = (state == STORE)  ? lat_wdata :
                         (state == RMW_WR) ? merge_val : 32'd0;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.rdata     = rdata_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      merge_buf    <= 32'd0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      rdata_r      <= 32'd0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_size     <= bus.req_size;
            lat_unsigned <= bus.req_unsigned;
            lat_addr     <= bus.req_addr;
            lat_wdata    <= bus.req_wdata;
            if (req_bad) begin
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else if (!bus.req_we)
              state <= LOAD;
            else if (bus.req_size == 2'b10)
              state <= STORE;
            else
              state <= RMW_RD;
          end
        end
        LOAD: begin
          rdata_r <= load_val;
          done_r  <= 1'b1;
          state   <= IDLE;
        end
        STORE: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
        RMW_RD: begin
          merge_buf <= bus.mem_rdata;
          state     <= RMW_WR;
        end
        RMW_WR: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl against a 256-word memory model whose reset
// contents are mem[i]=i.
module tb_lsu_ctrl;

  logic clk;
  logic rst;
  logic mem_init;
  int   vectors;
  int   miscompares;

  lsu_if bus ();

  lsu_ctrl #(.MEM_WORDS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  // Memory honours rst ahead of a write presented in the reset cycle.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (bus.MemWrite && !rst) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output int lat, output int rd_cnt, output int wr_cnt,
                                output logic err_seen, output logic [31:0] rdata_seen,
                                output logic done_after);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0000_0FFC;
    bus.req_wdata = 32'hDEAD_BEEF;
    lat        = 99;
    rd_cnt     = 0;
    wr_cnt     = 0;
    err_seen   = 1'b0;
    rdata_seen = 32'd0;
    for (int n = 1; n <= 8; n++) begin
      rd_cnt += int'(bus.MemRead);
      wr_cnt += int'(bus.MemWrite);
      if (bus.done) begin
        lat        = n;
        err_seen   = bus.err;
        rdata_seen = bus.rdata;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    done_after = bus.done;
  endtask

  int          lat, rd_cnt, wr_cnt, done_cnt;
  logic        err_seen, done_after;
  logic [31:0] rdata_seen;

  logic [31:0] ld_addr [5] = '{32'h21, 32'h22, 32'h22, 32'h22, 32'h22};
  logic [1:0]  ld_size [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
  logic        ld_uns  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] ld_exp  [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_80FF};

  logic [31:0] er_addr [4] = '{32'h23, 32'h06, 32'h00, 32'h400};
  logic [1:0]  er_size [4] = '{2'b01, 2'b10, 2'b11, 2'b10};

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    mem_init         = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_init = 1'b0;

    check_output("reset_ready", 32'(bus.req_ready), 32'd1);
    check_output("reset_done", 32'(bus.done), 32'd0);
    check_output("reset_err", 32'(bus.err), 32'd0);
    check_output("reset_rdata", bus.rdata, 32'd0);
    check_output("reset_memread", 32'(bus.MemRead), 32'd0);
    check_output("reset_memwrite", 32'(bus.MemWrite), 32'd0);
    check_output("reset_mem_addr", bus.mem_addr, 32'd0);
    check_output("reset_mem_wdata", bus.mem_wdata, 32'd0);

    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, lat, rd_cnt, wr_cnt, err_seen, rdata_seen, done_after);
    check_output("lw14_latency", 32'(lat), 32'd2);
    check_output("lw14_rd_cycles", 32'(rd_cnt), 32'd1);
    check_output("lw14_wr_cycles", 32'(wr_cnt), 32'd0);
    check_output("lw14_err", 32'(err_seen), 32'd0);
    check_output("lw14_rdata", rdata_seen, 32'h0000_0005);
    check_output("lw14_done_one_cycle", 32'(done_after), 32'd0);

    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01, lat, rd_cnt, wr_cnt, err_seen, rdata_seen, done_after);
    check_output("sw20_latency", 32'(lat), 32'd2);
    check_output("sw20_rd_cycles", 32'(rd_cnt), 32'd0);
    check_output("sw20_wr_cycles", 32'(wr_cnt), 32'd1);
    check_output("sw20_rdata_kept", rdata_seen, 32'h0000_0005);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, ld_size[i], ld_uns[i], ld_addr[i], 32'd0, lat, rd_cnt, wr_cnt, err_seen, rdata_seen, done_after);
      check_output($sformatf("ld%0d_latency", i), 32'(lat), 32'd2);
      check_output($sformatf("ld%0d_rdata", i), rdata_seen, ld_exp[i]);
    end

    apply_stimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AA, lat, rd_cnt, wr_cnt, err_seen, rdata_seen, done_after);
    check_output("sb21_latency", 32'(lat), 32'd3);
    check_output("sb21_rd_cycles", 32'(rd_cnt), 32'd1);
    check_output("sb21_wr_cycles", 32'(wr_cnt), 32'd1);
    check_output("sb21_rdata_kept", rdata_seen, 32'h0000_80FF);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, lat, rd_cnt, wr_cnt, err_seen, rdata_seen, done_after);
    check_output("sb21_readback", rdata_seen, 32'h80FF_AA01);

    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_1234, lat, rd_cnt, wr_cnt, err_seen, rdata_seen, done_after);
    check_output("sh22_latency", 32'(lat), 32'd3);
    check_output("sh22_wr_cycles", 32'(wr_cnt), 32'd1);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, lat, rd_cnt, wr_cnt, err_seen, rdata_seen, done_after);
    check_output("sh22_readback", rdata_seen, 32'h1234_AA01);

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, er_size[i], 1'b0, er_addr[i], 32'd0, lat, rd_cnt, wr_cnt, err_seen, rdata_seen, done_after);
      check_output($sformatf("err%0d_latency", i), 32'(lat), 32'd1);
      check_output($sformatf("err%0d_err", i), 32'(err_seen), 32'd1);
      check_output($sformatf("err%0d_strobes", i), 32'(rd_cnt + wr_cnt), 32'd0);
      check_output($sformatf("err%0d_rdata_kept", i), rdata_seen, 32'h1234_AA01);
    end

    done_cnt         = 0;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      done_cnt += int'(bus.done);
      check_output($sformatf("stream%0d_memread", i), 32'(bus.MemRead), 32'd1);
      bus.req_addr = 32'h40 + 32'(4 * (i + 1));
      @(posedge clk);
      #1;
      done_cnt += int'(bus.done);
      check_output($sformatf("stream%0d_rdata", i), bus.rdata, 32'h10 + 32'(i));
      check_output($sformatf("stream%0d_ready", i), 32'(bus.req_ready), 32'd1);
      if (i == 3) bus.req_valid = 1'b0;
    end
    check_output("stream_done_count", 32'(done_cnt), 32'd4);

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_output("rst_mid_in_rmw_rd", 32'(bus.MemRead), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check_output("rst_mid_done", 32'(bus.done), 32'd0);
    check_output("rst_mid_err", 32'(bus.err), 32'd0);
    check_output("rst_mid_rdata", bus.rdata, 32'd0);
    check_output("rst_mid_memread", 32'(bus.MemRead), 32'd0);
    check_output("rst_mid_memwrite", 32'(bus.MemWrite), 32'd0);
    check_output("rst_mid_mem_addr", bus.mem_addr, 32'd0);
    check_output("rst_mid_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    check_output("rst_mid_no_late_done", 32'(bus.done), 32'd0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, lat, rd_cnt, wr_cnt, err_seen, rdata_seen, done_after);
    check_output("rst_mid_word_untouched", rdata_seen, 32'h1234_AA01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
